// File: rtl/sci_op_pkt_fifo_pkg.sv
// Shared widths, packet layout and helpers for the operation-packet ingress FIFO.
// Packet layout, LSB first: data_x, then mode, then res in the MSBs.
package sci_op_pkt_fifo_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int RES_WIDTH  = 4;
  localparam int NUM_MODES  = 4;
  localparam int PKT_WIDTH  = RES_WIDTH + NUM_MODES + DATA_WIDTH;

  localparam int DATA_LSB   = 0;
  localparam int MODE_LSB   = DATA_LSB + DATA_WIDTH;
  localparam int RES_LSB    = MODE_LSB + NUM_MODES;

  localparam int DEPTH      = 8;
  localparam int ADDR_WIDTH = 3;

  // Packed so that res lands in the MSBs and data_x in the LSBs.
  typedef struct packed {
    logic [RES_WIDTH-1:0]  res;
    logic [NUM_MODES-1:0]  mode;
    logic [DATA_WIDTH-1:0] data_x;
  } op_pkt_t;

  function automatic logic mode_is_one_hot(input logic [NUM_MODES-1:0] m);
    return $onehot(m);
  endfunction

endpackage

// File: rtl/sci_op_pkt_fifo_if.sv
// Host push channel and core show-ahead/pop channel of the operation-packet FIFO.
// Push: a transfer happens on a rising edge where pkt_valid && pkt_ready; the host
// holds pkt_* stable while valid && !ready. Pop: fifo_pop consumes the head entry.
interface sci_op_pkt_fifo_if;
  import sci_op_pkt_fifo_pkg::*;

  logic                  pkt_valid;
  logic                  pkt_ready;
  logic [RES_WIDTH-1:0]  pkt_res;
  logic [NUM_MODES-1:0]  pkt_mode;
  logic [DATA_WIDTH-1:0] pkt_data_x;

  logic                  op_pkt_available;
  logic [RES_WIDTH-1:0]  res;
  logic [NUM_MODES-1:0]  mode;
  logic [DATA_WIDTH-1:0] data_x;
  logic                  fifo_pop;

  modport slave (
    input  pkt_valid, pkt_res, pkt_mode, pkt_data_x, fifo_pop,
    output pkt_ready, op_pkt_available, res, mode, data_x
  );

  modport master (
    output pkt_valid, pkt_res, pkt_mode, pkt_data_x, fifo_pop,
    input  pkt_ready, op_pkt_available, res, mode, data_x
  );

endinterface

// File: rtl/sci_op_pkt_fifo_ram.sv
// Packet storage: register array with one synchronous write port and an
// asynchronous read port. Contents are deliberately left unreset.
module pkt_fifo_ram #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int WIDTH      = 40
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sci_op_pkt_fifo.sv
// Ingress FIFO for compute-core operation packets: one-hot mode screening on push,
// show-ahead head packet for the core, sticky bad-mode and underflow flags.
module sci_op_pkt_fifo
  import sci_op_pkt_fifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  sci_op_pkt_fifo_if.slave      bus,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  bad_mode_err,
  output logic                  underflow_err,
  input  logic                  err_clr
);

  localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_nxt;

  logic          empty;
  logic          push_hs;
  logic          mode_ok;
  logic          push_store;
  logic          pop_ok;
  logic          pop_under;
  logic          set_bad;
  op_pkt_t       wr_pkt;
  op_pkt_t       rd_pkt;
  logic [PKT_WIDTH-1:0] rd_bits;

  assign empty         = (count == '0);
  // Ready comes only from the registered count, so a same-cycle pop never opens it.
  assign bus.pkt_ready = (count != FULL_COUNT);

  assign push_hs    = bus.pkt_valid && bus.pkt_ready;
  assign mode_ok    = mode_is_one_hot(bus.pkt_mode);
  assign push_store = push_hs && mode_ok;
  assign set_bad    = push_hs && !mode_ok;
  assign pop_ok     = bus.fifo_pop && !empty;
  assign pop_under  = bus.fifo_pop && empty;

  assign wr_pkt = '{res: bus.pkt_res, mode: bus.pkt_mode, data_x: bus.pkt_data_x};

  pkt_fifo_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WIDTH      (PKT_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_store),
    .waddr (wr_ptr),
    .wdata (wr_pkt),
    .raddr (rd_ptr),
    .rdata (rd_bits)
  );

  assign rd_pkt = op_pkt_t'(rd_bits);

  // Stale array contents must never leak out while the FIFO is empty.
  assign bus.op_pkt_available = !empty;
  assign bus.res    = empty ? '0 : rd_pkt.res;
  assign bus.mode   = empty ? '0 : rd_pkt.mode;
  assign bus.data_x = empty ? '0 : rd_pkt.data_x;
  assign fill_level = count;

  always_comb begin
    count_nxt = count;
    case ({push_store, pop_ok})
      2'b10:   count_nxt = count + CNT_ONE;
      2'b01:   count_nxt = count - CNT_ONE;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      bad_mode_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_store) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count <= count_nxt;

      // A fresh error event wins over a clear in the same cycle.
      if (set_bad) begin
        bad_mode_err <= 1'b1;
      end else if (err_clr) begin
        bad_mode_err <= 1'b0;
      end

      if (pop_under) begin
        underflow_err <= 1'b1;
      end else if (err_clr) begin
        underflow_err <= 1'b0;
      end
    end
  end

endmodule
